// File: rtl/seq_pkg.sv
// Shared encodings and helpers for the serial sequence generator/detector family.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } seq_state_t;

    localparam int unsigned DEFAULT_PAT_W = 3;
    localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PATTERN = 3'b101;

    // Registered transmit-side output bundle.
    typedef struct packed {
        logic seq_out;
        logic seq_valid;
        logic busy;
        logic done;
    } seq_tx_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Pattern load/shift register: holds the latched pattern and the index of the bit on the line.
module seq_piso
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = DEFAULT_PAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [PAT_W-1:0] pattern,
    output logic             last_bit,
    output logic             next_bit_c
);

    localparam int unsigned CNT_W = cnt_width(PAT_W);
    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Index wraps to the MSB after bit 0 so repetitions need no reload.
    always_comb begin
        pat_d = pat_q;
        cnt_d = cnt_q;
        if (load) begin
            pat_d = pattern;
            cnt_d = TOP_IDX;
        end else if (advance) begin
            cnt_d = (cnt_q == '0) ? TOP_IDX : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_bit   = (cnt_q == '0);
    // Bit that will be on the line after the coming edge, so the top can register it.
    assign next_bit_c = pat_d[cnt_d];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, a programmable number of times.
// Optional idle gap between repetitions is enabled by defining SEQ_GEN_GAP_EN.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W   = DEFAULT_PAT_W,
    parameter int unsigned REP_W   = 4,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    if (PAT_W < 2 || REP_W < 1 || GAP_LEN < 1) begin : g_param_check
        $error("seq_pattern_gen: PAT_W must be >= 2, REP_W >= 1, GAP_LEN >= 1");
    end

    seq_state_t       state;
    seq_state_t       state_d;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
    seq_tx_t          tx_q;
    seq_tx_t          tx_d;
    logic             load;
    logic             advance;
    logic             last_bit;
    logic             next_bit_c;

`ifdef SEQ_GEN_GAP_EN
    localparam int unsigned GAP_W = cnt_width(GAP_LEN + 1);
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
`endif

    seq_piso #(
        .PAT_W (PAT_W)
    ) u_piso (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .advance    (advance),
        .pattern    (pattern),
        .last_bit   (last_bit),
        .next_bit_c (next_bit_c)
    );

    // Next state plus the output values that will be registered alongside it.
    always_comb begin
        state_d = state;
        rep_d   = rep_q;
        load    = 1'b0;
        advance = 1'b0;
        tx_d    = '0;
`ifdef SEQ_GEN_GAP_EN
        gap_d   = gap_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start && reps != '0) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                    rep_d   = reps;
                end else if (start) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                advance = 1'b1;
                if (last_bit) begin
                    if (rep_q == REP_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        rep_d = rep_q - REP_W'(1);
`ifdef SEQ_GEN_GAP_EN
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_LEN - 1);
`else
                        state_d = SHIFT;
`endif
                    end
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SHIFT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        tx_d.seq_valid = (state_d == SHIFT);
        tx_d.seq_out   = (state_d == SHIFT) && next_bit_c;
        tx_d.busy      = (state_d == SHIFT) || (state_d == GAP);
        tx_d.done      = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rep_q <= '0;
            tx_q  <= '0;
`ifdef SEQ_GEN_GAP_EN
            gap_q <= '0;
`endif
        end else begin
            state <= state_d;
            rep_q <= rep_d;
            tx_q  <= tx_d;
`ifdef SEQ_GEN_GAP_EN
            gap_q <= gap_d;
`endif
        end
    end

    assign seq_out   = tx_q.seq_out;
    assign seq_valid = tx_q.seq_valid;
    assign busy      = tx_q.busy;
    assign done      = tx_q.done;

endmodule
